// File: rtl/ysyx_25030093_pkg.sv
// Shared types and constants for the memory arbiter slice.
package ysyx_25030093_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    // Instruction fetches are always full-word accesses
    localparam logic [1:0] IFU_SIZE = 2'b10;

endpackage

// File: rtl/ysyx_25030093_wdog.sv
// Request watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT_CYC-th enabled cycle is reached.
// TIMEOUT_CYC = 0 never expires.
module ysyx_25030093_wdog #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned   CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count;

    // Cycle counter, restarted whenever a new request is granted
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    // count holds the number of completed enabled cycles, so the current
    // cycle is the TIMEOUT_CYC-th one when count equals TIMEOUT_CYC-1
    assign expired = (TIMEOUT_CYC != 0) && enable && (count == LAST);

endmodule

// File: rtl/ysyx_25030093_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto a single downstream memory port.
// LSU has priority; one transaction in flight at a time; a watchdog
// terminates a silent request with zero data and a sticky bus_err.
module ysyx_25030093_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        mem_reqValid,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);
    import ysyx_25030093_pkg::*;

    arb_state_e  state;
    owner_e      owner;
    logic        guard_valid;
    owner_e      guard_owner;
    logic [31:0] capture;

    logic ifu_elig;
    logic lsu_elig;
    logic grant;
    logic in_req;
    logic wd_expired;
    logic req_end;

    // Eligibility after the served-port guard, and end-of-request detection
    always_comb begin
        ifu_elig = ifu_reqValid && !(guard_valid && (guard_owner == OWN_IFU));
        lsu_elig = lsu_reqValid && !(guard_valid && (guard_owner == OWN_LSU));
        grant    = (state == ST_IDLE) && (ifu_elig || lsu_elig);
        in_req   = (state == ST_REQ);
        req_end  = in_req && (mem_respValid || wd_expired);
    end

    ysyx_25030093_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (grant),
        .enable (in_req),
        .expired(wd_expired)
    );

    assign ifu_rdata = capture;
    assign lsu_rdata = capture;

    // Arbitration FSM with registered downstream payload and response pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            owner         <= OWN_IFU;
            guard_valid   <= 1'b0;
            guard_owner   <= OWN_IFU;
            capture       <= '0;
            ifu_respValid <= 1'b0;
            lsu_respValid <= 1'b0;
            mem_reqValid  <= 1'b0;
            mem_addr      <= '0;
            mem_size      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            bus_err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    guard_valid <= 1'b0;
                    if (lsu_elig) begin
                        owner        <= OWN_LSU;
                        mem_addr     <= lsu_addr;
                        mem_size     <= lsu_size;
                        mem_wen      <= lsu_wen;
                        mem_wdata    <= lsu_wdata;
                        mem_wmask    <= lsu_wen ? lsu_wmask : 4'h0;
                        mem_reqValid <= 1'b1;
                        state        <= ST_REQ;
                    end else if (ifu_elig) begin
                        owner        <= OWN_IFU;
                        mem_addr     <= ifu_addr;
                        mem_size     <= IFU_SIZE;
                        mem_wen      <= 1'b0;
                        mem_wdata    <= '0;
                        mem_wmask    <= 4'h0;
                        mem_reqValid <= 1'b1;
                        state        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A response arriving in the timeout cycle takes precedence
                    if (req_end) begin
                        capture       <= mem_respValid ? mem_rdata : '0;
                        bus_err       <= bus_err | ~mem_respValid;
                        ifu_respValid <= (owner == OWN_IFU);
                        lsu_respValid <= (owner == OWN_LSU);
                        mem_reqValid  <= 1'b0;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ifu_respValid <= 1'b0;
                    lsu_respValid <= 1'b0;
                    guard_valid   <= 1'b1;
                    guard_owner   <= owner;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030093_mem_arbiter.sv
// Randomized bench for the memory arbiter. The bench plays both upstream
// masters and the downstream memory; expectations come from transaction-level
// rules: grant order, latency = min(delay+1, TO) REQ cycles, zero data and a
// sticky error on timeout.
module tb_ysyx_25030093_mem_arbiter;

    localparam int unsigned TO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_reqValid;
    logic [31:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_respValid;
    logic [31:0] mem_rdata;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;
    logic m_bus_err = 1'b0;

    always #5 clock = ~clock;

    ysyx_25030093_mem_arbiter #(
        .TIMEOUT_CYC(TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ifu_reqValid (ifu_reqValid),
        .ifu_addr     (ifu_addr),
        .ifu_respValid(ifu_respValid),
        .ifu_rdata    (ifu_rdata),
        .lsu_reqValid (lsu_reqValid),
        .lsu_addr     (lsu_addr),
        .lsu_size     (lsu_size),
        .lsu_wen      (lsu_wen),
        .lsu_wdata    (lsu_wdata),
        .lsu_wmask    (lsu_wmask),
        .lsu_respValid(lsu_respValid),
        .lsu_rdata    (lsu_rdata),
        .mem_reqValid (mem_reqValid),
        .mem_addr     (mem_addr),
        .mem_size     (mem_size),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_respValid(mem_respValid),
        .mem_rdata    (mem_rdata),
        .bus_err      (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Stray downstream responses while not in a request must be ignored
    task automatic spur();
        mem_respValid = 1'($urandom_range(0, 1));
        mem_rdata     = $urandom;
    endtask

    task automatic req_ifu(input logic [31:0] a);
        ifu_reqValid = 1'b1;
        ifu_addr     = a;
    endtask

    task automatic req_lsu(input logic [31:0] a, input logic [1:0] sz, input logic w,
                           input logic [31:0] wd, input logic [3:0] wm);
        lsu_reqValid = 1'b1;
        lsu_addr     = a;
        lsu_size     = sz;
        lsu_wen      = w;
        lsu_wdata    = wd;
        lsu_wmask    = wm;
    endtask

    task automatic drop(input logic is_lsu);
        if (is_lsu) lsu_reqValid = 1'b0;
        else        ifu_reqValid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clock);
            chk("idle_reqValid", 32'(mem_reqValid), 32'd0);
            chk("idle_resp", 32'({ifu_respValid, lsu_respValid}), 32'd0);
            spur();
        end
    endtask

    // Called at a negedge where the owner's request is visible and the arbiter
    // is idle. Memory answers d cycles after the request rises (d >= TO: silent).
    task automatic serve(input logic is_lsu, input int unsigned d, input logic [31:0] rd,
                         input logic hold_extra);
        logic        tmo;
        int unsigned len;
        logic [31:0] exp_data;
        tmo      = (d >= TO);
        len      = tmo ? TO : d + 1;
        exp_data = tmo ? 32'h0 : rd;
        for (int unsigned k = 0; k < len; k++) begin
            @(negedge clock);
            chk("req_active", 32'(mem_reqValid), 32'd1);
            chk("no_early_resp", 32'({ifu_respValid, lsu_respValid}), 32'd0);
            if (k == 0) begin
                if (is_lsu) begin
                    chk("lsu_mem_addr", mem_addr, lsu_addr);
                    chk("lsu_mem_size", 32'(mem_size), 32'(lsu_size));
                    chk("lsu_mem_wen", 32'(mem_wen), 32'(lsu_wen));
                    chk("lsu_mem_wdata", mem_wdata, lsu_wdata);
                    chk("lsu_mem_wmask", 32'(mem_wmask), lsu_wen ? 32'(lsu_wmask) : 32'd0);
                end else begin
                    chk("ifu_mem_addr", mem_addr, ifu_addr);
                    chk("ifu_mem_size", 32'(mem_size), 32'd2);
                    chk("ifu_mem_wen", 32'(mem_wen), 32'd0);
                    chk("ifu_mem_wdata", mem_wdata, 32'd0);
                    chk("ifu_mem_wmask", 32'(mem_wmask), 32'd0);
                end
            end
            mem_respValid = (k == d);
            mem_rdata     = (k == d) ? rd : $urandom;
        end
        @(negedge clock);
        m_bus_err = m_bus_err | tmo;
        chk("done_reqValid", 32'(mem_reqValid), 32'd0);
        chk("ifu_respValid", 32'(ifu_respValid), 32'(!is_lsu));
        chk("lsu_respValid", 32'(lsu_respValid), 32'(is_lsu));
        chk("rdata", is_lsu ? lsu_rdata : ifu_rdata, exp_data);
        chk("bus_err", 32'(bus_err), 32'(m_bus_err));
        spur();
        if (!hold_extra) drop(is_lsu);
        @(negedge clock);
        chk("resp_one_cycle", 32'({ifu_respValid, lsu_respValid}), 32'd0);
        chk("guard_reqValid", 32'(mem_reqValid), 32'd0);
        spur();
        if (hold_extra) begin
            @(negedge clock);
            chk("no_regrant", 32'(mem_reqValid), 32'd0);
            drop(is_lsu);
            spur();
        end
    endtask

    // Reset while a request is outstanding; the late response must vanish
    task automatic reset_in_req(input logic is_lsu);
        idle(1);
        if (is_lsu) req_lsu($urandom, 2'd2, 1'b0, $urandom, 4'hF);
        else        req_ifu($urandom);
        @(negedge clock);
        chk("rst_req_up", 32'(mem_reqValid), 32'd1);
        mem_respValid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset         = 1'b0;
        ifu_reqValid  = 1'b0;
        lsu_reqValid  = 1'b0;
        mem_respValid = 1'b1;
        mem_rdata     = $urandom;
        m_bus_err     = 1'b0;
        chk("rst_reqValid", 32'(mem_reqValid), 32'd0);
        chk("rst_resp", 32'({ifu_respValid, lsu_respValid}), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clock);
        mem_respValid = 1'b0;
        chk("late_resp_dropped", 32'({ifu_respValid, lsu_respValid}), 32'd0);
        chk("late_reqValid", 32'(mem_reqValid), 32'd0);
    endtask

    function automatic int unsigned pick_delay();
        int unsigned r;
        r = $urandom_range(0, 19);
        if (r < 14)      return $urandom_range(0, 4);
        else if (r < 16) return TO - 1;
        else             return $urandom_range(TO, TO + 3);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "time limit");
    end

    initial begin
        int unsigned kind;
        reset         = 1'b1;
        ifu_reqValid  = 1'b0;
        ifu_addr      = '0;
        lsu_reqValid  = 1'b0;
        lsu_addr      = '0;
        lsu_size      = '0;
        lsu_wen       = 1'b0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        mem_respValid = 1'b0;
        mem_rdata     = '0;

        repeat (2) @(negedge clock);
        chk("rst_mem_reqValid", 32'(mem_reqValid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_payload", {mem_wdata[29:0], mem_size}, 32'd0);
        chk("rst_mem_ctl", 32'({mem_wen, mem_wmask}), 32'd0);
        chk("rst_resp", 32'({ifu_respValid, lsu_respValid}), 32'd0);
        chk("rst_rdata", ifu_rdata | lsu_rdata, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        reset = 1'b0;

        // Fetch with same-cycle memory response
        idle(1);
        req_ifu(32'h8000_0000);
        serve(1'b0, 0, 32'h0000_0413, 1'b0);

        // Fetch request held one cycle past completion
        idle(1);
        req_ifu(32'h8000_0004);
        serve(1'b0, 1, $urandom, 1'b1);

        // Simultaneous requests: LSU store first, then fetch
        idle(1);
        req_ifu(32'h8000_0004);
        req_lsu(32'h8000_1000, 2'd2, 1'b1, 32'h1234_5678, 4'hF);
        serve(1'b1, 0, $urandom, 1'b0);
        serve(1'b0, 0, $urandom, 1'b0);

        // Response in the last cycle before timeout wins
        idle(1);
        req_lsu(32'h8000_2000, 2'd2, 1'b0, $urandom, 4'hF);
        serve(1'b1, TO - 1, 32'hCAFE_F00D, 1'b0);

        // Silent memory: timeout with zero data, sticky error
        idle(1);
        req_lsu(32'h8000_3000, 2'd2, 1'b0, $urandom, 4'h0);
        serve(1'b1, TO + 2, $urandom, 1'b0);
        idle(2);
        req_ifu(32'h8000_0008);
        serve(1'b0, 0, $urandom, 1'b0);

        reset_in_req(1'b1);
        reset_in_req(1'b0);

        for (int g = 0; g < 60; g++) begin
            kind = $urandom_range(0, 2);
            idle($urandom_range(1, 3));
            if (kind != 1) req_ifu($urandom);
            if (kind != 0) req_lsu($urandom, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                                   $urandom, 4'($urandom_range(0, 15)));
            if (kind == 2) begin
                serve(1'b1, pick_delay(), $urandom, 1'b0);
                serve(1'b0, pick_delay(), $urandom, 1'b0);
            end else begin
                serve(kind == 1, pick_delay(), $urandom, 1'($urandom_range(0, 1)));
            end
            if (g % 15 == 14) reset_in_req(1'($urandom_range(0, 1)));
        end

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25030093_mem_arbiter.md
YSYX_25030093_MEM_ARBITER -- requirements
Module: ysyx_25030093_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024, sets the maximum REQ-state cycles waited for mem_respValid; 0 disables the timeout.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 clock  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ifu_reqValid  input  1  fetch request, held high with ifu_addr stable until ifu_respValid.
REQ-006 ifu_addr  input  32  fetch address.
REQ-007 ifu_respValid  output  1  one-cycle fetch completion pulse.
REQ-008 ifu_rdata  output  32  fetched word, valid while ifu_respValid=1.
REQ-009 lsu_reqValid  input  1  load/store request, held high with payload stable until lsu_respValid.
REQ-010 lsu_addr  input  32  load/store address.
REQ-011 lsu_size  input  2  access size (0=byte, 1=half, 2=word).
REQ-012 lsu_wen  input  1  1=store, 0=load.
REQ-013 lsu_wdata  input  32  store data, lane-aligned.
REQ-014 lsu_wmask  input  4  store byte strobes.
REQ-015 lsu_respValid  output  1  one-cycle load/store completion pulse.
REQ-016 lsu_rdata  output  32  load word, valid while lsu_respValid=1.
REQ-017 mem_reqValid  output  1  downstream request, held until mem_respValid or timeout.
REQ-018 mem_addr  output  32  latched address of granted master.
REQ-019 mem_size  output  2  latched size; 2'b10 for IFU.
REQ-020 mem_wen  output  1  latched write enable; 0 for IFU.
REQ-021 mem_wdata  output  32  latched store data; 0 for IFU.
REQ-022 mem_wmask  output  4  latched strobes; 4'h0 for IFU and for loads.
REQ-023 mem_respValid  input  1  downstream completion pulse.
REQ-024 mem_rdata  input  32  downstream read data, valid with mem_respValid.
REQ-025 bus_err  output  1  sticky timeout flag.

Function
REQ-026 FSM states: IDLE, REQ, DONE; IDLE->REQ on grant; REQ->DONE on mem_respValid or timeout; DONE->IDLE unconditionally.
REQ-027 Grant in IDLE: LSU wins over IFU when both request in the same cycle; owner and full payload latched on the grant edge.
REQ-028 mem_reqValid=1 exactly while in REQ; mem_* payload outputs come from latch registers only, never combinationally from upstream.
REQ-029 In REQ, mem_respValid latches mem_rdata into a shared capture register; in DONE, only the owner's respValid is 1 and both rdata outputs drive the capture register.
REQ-030 Minimum latency: request seen in IDLE at cycle N -> mem_reqValid at N+1 -> same-cycle mem_respValid -> owner respValid at N+2.
REQ-031 Served-port guard: the IDLE cycle immediately after DONE ignores the master just served, so a reqValid still high for that one cycle does not re-grant.
REQ-032 Timeout counter clears on REQ entry and increments each REQ cycle; reaching TIMEOUT_CYC without mem_respValid -> DONE with capture=0 and bus_err set.
REQ-033 mem_respValid and timeout in the same cycle: response wins, real data returned, bus_err unchanged.
REQ-034 mem_respValid outside REQ SHALL be ignored.
REQ-035 bus_err stays high until reset.

Reset
REQ-036 Reset SHALL force IDLE and clear all outputs, latches, counter, guard and bus_err to 0; an in-flight request is aborted and its later mem_respValid is dropped.

Structure
REQ-037 State encoding and owner enum (OWN_IFU, OWN_LSU) SHALL live in shared package ysyx_25030093_pkg with the IFU size constant 2'b10.
REQ-038 Timeout counter SHALL be sub-module ysyx_25030093_wdog (clear, enable, expired).

Verification
REQ-039 IFU read 0x8000_0000; mem responds at N+1 with 0x0000_0413 -> ifu_respValid at N+2, ifu_rdata=0x0000_0413, lsu_respValid=0.
REQ-040 IFU 0x8000_0004 and LSU store 0x8000_1000/0x1234_5678/4'hF in the same cycle -> LSU served first (mem_wen=1), then IFU; one respValid each.
REQ-041 TIMEOUT_CYC=8, LSU load, mem silent -> lsu_respValid after 8 REQ cycles, lsu_rdata=0, bus_err=1 until reset.
REQ-042 ifu_reqValid held one cycle past ifu_respValid -> no second mem_reqValid.
REQ-043 Reset asserted in REQ, mem_respValid next cycle -> no upstream respValid, mem_reqValid=0.
REQ-044 TIMEOUT_CYC=8, mem_respValid on 8th REQ cycle with 0xCAFE_F00D -> rdata 0xCAFE_F00D, bus_err=0.
